// File: rtl/bus_rr_arbiter_pkg.sv
// Shared types and defaults for the four-master round-robin bus arbiter.
// Holds state encodings, index width and the one-hot helper.
package bus_rr_arbiter_pkg;

   localparam int BUS_MASTER_W = 2;
   localparam int NUM_MASTERS  = 4;
   localparam int MAX_HOLD_DEF = 16;
   localparam int TIMEOUT_DEF  = 256;
   localparam int WD_W_DEF     = 9;

   typedef logic [BUS_MASTER_W-1:0] mst_idx_t;

   typedef enum logic [1:0] {
      ARB_IDLE  = 2'd0,
      ARB_OWN   = 2'd1,
      ARB_ABORT = 2'd2
   } arb_state_e;

   function automatic logic [NUM_MASTERS-1:0] mst_onehot(mst_idx_t i);
      return NUM_MASTERS'(1) << i;
   endfunction

endpackage

// File: rtl/bus_rr_arbiter_pick.sv
// Rotating-priority encoder: first requester after lastOwner wins,
// lastOwner itself is considered last.
module bus_rr_pick
   import bus_rr_arbiter_pkg::*;
(
   input  logic [NUM_MASTERS-1:0] req_i,
   input  mst_idx_t               lastOwner_i,
   output mst_idx_t               pick_o,
   output logic                   anyReq_o
);

   mst_idx_t cand;

   // Walk from the farthest candidate down so the nearest one overwrites.
   always_comb begin
      pick_o = lastOwner_i;
      cand   = lastOwner_i;
      for (int k = NUM_MASTERS; k >= 1; k--) begin
         cand = lastOwner_i + mst_idx_t'(k);
         if (req_i[cand]) pick_o = cand;
      end
   end

   assign anyReq_o = |req_i;

endmodule

// File: rtl/bus_rr_arbiter.sv
// Round-robin grant FSM for the shared bus, with a bounded hold quantum
// and a transfer watchdog that revokes grants stuck without ready.
module bus_rr_arbiter
   import bus_rr_arbiter_pkg::*;
#(
   parameter int MAX_HOLD       = MAX_HOLD_DEF,
   parameter int TIMEOUT_CYCLES = TIMEOUT_DEF,
   parameter int WD_W           = WD_W_DEF
) (
   input  logic       clk,
   input  logic       reset_,
   input  logic       m0Req_,
   input  logic       m1Req_,
   input  logic       m2Req_,
   input  logic       m3Req_,
   input  logic       sAs_,
   input  logic       mRdy_,
   output logic       m0Grnt_,
   output logic       m1Grnt_,
   output logic       m2Grnt_,
   output logic       m3Grnt_,
   output logic [1:0] owner,
   output logic       ownerVld,
   output logic       busErr,
   output logic [1:0] errMaster
);

   localparam int HOLD_W = $clog2(MAX_HOLD + 1);

   arb_state_e             state_q, state_d;
   logic [NUM_MASTERS-1:0] grnt_q, grnt_d;
   logic [NUM_MASTERS-1:0] blk_q, blk_d;
   mst_idx_t               owner_q, owner_d;
   mst_idx_t               last_q, last_d;
   mst_idx_t               errMst_q, errMst_d;
   logic                   vld_q, vld_d;
   logic                   busErr_q, busErr_d;
   logic [HOLD_W-1:0]      holdCnt_q, holdCnt_d;
   logic [WD_W-1:0]        wdCnt_q, wdCnt_d;

   logic [NUM_MASTERS-1:0] req, elig;
   mst_idx_t               pick;
   logic                   anyReq;
   logic                   stall, ownReq, othReq;
   logic                   wdHit, preempt, relGo;

   assign req  = ~{m3Req_, m2Req_, m1Req_, m0Req_};
   // A master aborted by the watchdog stays ineligible until it lets go.
   assign elig = req & ~blk_q;

   bus_rr_pick u_pick (
      .req_i       (elig),
      .lastOwner_i (last_q),
      .pick_o      (pick),
      .anyReq_o    (anyReq)
   );

   assign stall   = !sAs_ && mRdy_;
   assign ownReq  = req[owner_q];
   assign othReq  = |(elig & ~mst_onehot(owner_q));
   assign wdHit   = stall && (wdCnt_q == WD_W'(TIMEOUT_CYCLES - 1));
   assign preempt = (holdCnt_q == HOLD_W'(MAX_HOLD)) && othReq && sAs_;
   assign relGo   = !ownReq || (!wdHit && preempt);

   always_comb begin
      state_d   = state_q;
      grnt_d    = grnt_q;
      owner_d   = owner_q;
      last_d    = last_q;
      vld_d     = vld_q;
      busErr_d  = 1'b0;
      errMst_d  = errMst_q;
      holdCnt_d = holdCnt_q;
      wdCnt_d   = '0;
      blk_d     = blk_q & req;
      unique case (state_q)
         ARB_IDLE: begin
            if (anyReq) begin
               state_d   = ARB_OWN;
               grnt_d    = mst_onehot(pick);
               owner_d   = pick;
               vld_d     = 1'b1;
               holdCnt_d = '0;
            end
         end
         ARB_OWN: begin
            if (holdCnt_q != HOLD_W'(MAX_HOLD)) holdCnt_d = holdCnt_q + 1'b1;
            if (stall) wdCnt_d = wdCnt_q + 1'b1;
            if (relGo) begin
               state_d = ARB_IDLE;
               grnt_d  = '0;
               vld_d   = 1'b0;
               last_d  = owner_q;
            end else if (wdHit) begin
               state_d  = ARB_ABORT;
               grnt_d   = '0;
               vld_d    = 1'b0;
               last_d   = owner_q;
               busErr_d = 1'b1;
               errMst_d = owner_q;
               blk_d    = (blk_q & req) | mst_onehot(owner_q);
            end
         end
         ARB_ABORT: state_d = ARB_IDLE;
         default:   state_d = ARB_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_) begin
         state_q   <= ARB_IDLE;
         grnt_q    <= '0;
         blk_q     <= '0;
         owner_q   <= '0;
         last_q    <= mst_idx_t'(NUM_MASTERS - 1);
         errMst_q  <= '0;
         vld_q     <= 1'b0;
         busErr_q  <= 1'b0;
         holdCnt_q <= '0;
         wdCnt_q   <= '0;
      end else begin
         state_q   <= state_d;
         grnt_q    <= grnt_d;
         blk_q     <= blk_d;
         owner_q   <= owner_d;
         last_q    <= last_d;
         errMst_q  <= errMst_d;
         vld_q     <= vld_d;
         busErr_q  <= busErr_d;
         holdCnt_q <= holdCnt_d;
         wdCnt_q   <= wdCnt_d;
      end
   end

   assign m0Grnt_   = ~grnt_q[0];
   assign m1Grnt_   = ~grnt_q[1];
   assign m2Grnt_   = ~grnt_q[2];
   assign m3Grnt_   = ~grnt_q[3];
   assign owner     = owner_q;
   assign ownerVld  = vld_q;
   assign busErr    = busErr_q;
   assign errMaster = errMst_q;

endmodule
